// File: rtl/vect_store_serializer.sv
// vect_store_serializer: takes one whole vector store from the pipe register
// and writes its enabled lanes, lowest index first, one per cycle to a scalar
// memory write port. Upstream is held off (stall) until the store completes.
// Ports: clk, reset (async, active-low), in_valid/in_ready, base_addr, vect,
//   lane_mask, mem_we/mem_addr/mem_wdata/mem_ready, stall, busy, done.
// Optional VSTORE_STRIDE_EN adds input 'stride': lane i goes to base+i*stride.
module vect_store_serializer #(
    parameter int WIDTH        = 8,
    parameter int registerSize = 16,
    parameter int vectorSize   = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [WIDTH-1:0]                       base_addr,
`ifdef VSTORE_STRIDE_EN
    input  logic [WIDTH-1:0]                       stride,
`endif
    input  logic [vectorSize-1:0][registerSize-1:0] vect,
    input  logic [vectorSize-1:0]                  lane_mask,
    output logic                                   mem_we,
    output logic [WIDTH-1:0]                       mem_addr,
    output logic [registerSize-1:0]                mem_wdata,
    input  logic                                   mem_ready,
    output logic                                   stall,
    output logic                                   busy,
    output logic                                   done
);

    localparam int LW = (vectorSize > 1) ? $clog2(vectorSize) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                                  r_state;
    logic [vectorSize-1:0][registerSize-1:0] r_vect;
    logic [WIDTH-1:0]                        r_base;
    // Lanes still to be presented; the lane on mem_* is already cleared here.
    logic [vectorSize-1:0]                   r_rem;
`ifdef VSTORE_STRIDE_EN
    logic [WIDTH-1:0]                        r_stride;
`endif

    logic [LW-1:0]         w_cap_cur;
    logic [LW-1:0]         w_nxt_cur;
    logic [vectorSize-1:0] w_cap_rem;
    logic [vectorSize-1:0] w_nxt_rem;
    logic [WIDTH-1:0]      w_cap_stride;
    logic [WIDTH-1:0]      w_run_stride;
    logic [WIDTH-1:0]      w_cap_addr;
    logic [WIDTH-1:0]      w_nxt_addr;

    // Priority encoder: index of the lowest set bit (0 when none set).
    function automatic logic [LW-1:0] f_lowest(input logic [vectorSize-1:0] m);
        f_lowest = '0;
        for (int i = vectorSize - 1; i >= 0; i--) begin
            if (m[i]) f_lowest = LW'(i);
        end
    endfunction

    always_comb begin
`ifdef VSTORE_STRIDE_EN
        w_cap_stride = stride;
        w_run_stride = r_stride;
`else
        w_cap_stride = WIDTH'(1);
        w_run_stride = WIDTH'(1);
`endif
        w_cap_cur  = f_lowest(lane_mask);
        w_nxt_cur  = f_lowest(r_rem);
        // m & (m-1) drops the lowest set bit
        w_cap_rem  = lane_mask & (lane_mask - vectorSize'(1));
        w_nxt_rem  = r_rem & (r_rem - vectorSize'(1));
        w_cap_addr = base_addr + WIDTH'(w_cap_cur) * w_cap_stride;
        w_nxt_addr = r_base + WIDTH'(w_nxt_cur) * w_run_stride;
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign stall    = in_valid & ~in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_vect    <= '0;
            r_base    <= '0;
            r_rem     <= '0;
`ifdef VSTORE_STRIDE_EN
            r_stride  <= '0;
`endif
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (in_valid) begin
                        r_vect <= vect;
                        r_base <= base_addr;
`ifdef VSTORE_STRIDE_EN
                        r_stride <= stride;
`endif
                        if (lane_mask == '0) begin
                            r_rem   <= '0;
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            // First lane is presented straight from the inputs
                            r_rem     <= w_cap_rem;
                            r_state   <= S_SEND;
                            mem_we    <= 1'b1;
                            mem_addr  <= w_cap_addr;
                            mem_wdata <= vect[w_cap_cur];
                        end
                    end
                end
                S_SEND: begin
                    if (mem_ready) begin
                        if (r_rem == '0) begin
                            mem_we  <= 1'b0;
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_rem     <= w_nxt_rem;
                            mem_addr  <= w_nxt_addr;
                            mem_wdata <= r_vect[w_nxt_cur];
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    mem_we  <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
